// File: rtl/puc_reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : puc_reset_sequencer_pkg
// Description : Shared types and constants for the PUC reset sequencer and
//               the access monitors that feed it.
// Revision    : 1.0 - initial release
// ============================================================================
package puc_reset_sequencer_pkg;

    // Width of the violation counter
    localparam int CNT_W = 8;

    // Reset vector address the core fetches after PUC release
    localparam logic [15:0] C_RESET_HANDLER = 16'hFFFE;

    // Sequencer states; LOCKED is reachable only with the lockout build
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_WAIT_VEC = 2'd2,
        ST_LOCKED   = 2'd3
    } seq_state_t;

    // Saturating increment: sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage : puc_reset_sequencer_pkg
`default_nettype wire

// File: rtl/puc_reset_sequencer_timer.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_timer
// Description : 16-bit loadable down-counter with zero flag. Shared by the
//               PUC hold window and the reset-vector wait window.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    output logic        zero
);

    logic [15:0] r_count;

    // Load has priority over counting; counting stops at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 16'd0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != 16'd0)) begin
            r_count <= r_count - 16'd1;
        end
    end

    assign zero = (r_count == 16'd0);

endmodule : rst_seq_timer
`default_nettype wire

// File: rtl/puc_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : puc_reset_sequencer
// Description : Collects monitor violation requests, holds the CPU PUC for a
//               fixed window, then waits for the core to reach the reset
//               vector. Records the firing monitors and a saturating count.
//               Optional macro RST_SEQ_LOCKOUT_EN: latch PUC permanently once
//               the violation count reaches LOCK_THRESH.
// Revision    : 1.0 - initial release
// ============================================================================
module puc_reset_sequencer
    import puc_reset_sequencer_pkg::*;
#(
    parameter int          NUM_SRC       = 4,
    parameter logic [15:0] HOLD_CYCLES   = 16'd8,
    parameter logic [15:0] WAIT_MAX      = 16'd32,
    parameter logic [15:0] RESET_HANDLER = C_RESET_HANDLER,
    parameter logic [7:0]  LOCK_THRESH   = 8'd4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] viol_req,
    input  logic [15:0]        pc,
    input  logic               cause_clr,
    output logic               puc_rst,
    output logic               viol_ack,
    output logic [NUM_SRC-1:0] cause,
    output logic [CNT_W-1:0]   viol_cnt,
    output logic               busy
);

    seq_state_t         r_state;
    logic               r_puc_rst;
    logic               r_viol_ack;
    logic [NUM_SRC-1:0] r_cause;
    logic [CNT_W-1:0]   r_viol_cnt;

    logic               w_req_any;
    logic               w_at_vector;
    logic [CNT_W-1:0]   w_cnt_inc;
    seq_state_t         w_seq_state;
    logic               w_tmr_load;
    logic [15:0]        w_tmr_load_val;
    logic               w_tmr_en;
    logic               w_tmr_zero;

    assign w_req_any   = |viol_req;
    assign w_at_vector = (pc == RESET_HANDLER);
    assign w_cnt_inc   = sat_inc(r_viol_cnt);

`ifdef RST_SEQ_LOCKOUT_EN
    // A new sequence that reaches the threshold locks instead of holding
    assign w_seq_state = (w_cnt_inc >= LOCK_THRESH) ? ST_LOCKED : ST_HOLD;
`else
    logic w_unused_lock_thresh;
    assign w_unused_lock_thresh = ^LOCK_THRESH;
    assign w_seq_state          = ST_HOLD;
`endif

    // Timer control: reload on every window start, count down inside a window
    always_comb begin
        w_tmr_load     = 1'b0;
        w_tmr_load_val = HOLD_CYCLES - 16'd1;
        w_tmr_en       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tmr_load = w_req_any;
            end
            ST_HOLD: begin
                if (w_tmr_zero) begin
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = WAIT_MAX - 16'd1;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_WAIT_VEC: begin
                if (w_at_vector && !w_req_any) begin
                    w_tmr_load = 1'b0;
                end else if (w_req_any || w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            default: begin
                w_tmr_load = 1'b0;
            end
        endcase
    end

    rst_seq_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_tmr_load),
        .load_val (w_tmr_load_val),
        .en       (w_tmr_en),
        .zero     (w_tmr_zero)
    );

    // Sequencer FSM with registered PUC, ack, cause and count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_puc_rst  <= 1'b0;
            r_viol_ack <= 1'b0;
            r_cause    <= '0;
            r_viol_cnt <= '0;
        end else begin
            r_viol_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A live request beats a simultaneous clear
                    if (w_req_any) begin
                        r_cause    <= r_cause | viol_req;
                        r_viol_cnt <= w_cnt_inc;
                        r_state    <= w_seq_state;
                        r_puc_rst  <= 1'b1;
                    end else if (cause_clr) begin
                        r_cause <= '0;
                    end
                end
                ST_HOLD: begin
                    r_cause <= r_cause | viol_req;
                    if (w_tmr_zero) begin
                        r_state   <= ST_WAIT_VEC;
                        r_puc_rst <= 1'b0;
                    end
                end
                ST_WAIT_VEC: begin
                    if (w_at_vector && !w_req_any) begin
                        r_state    <= ST_IDLE;
                        r_viol_ack <= 1'b1;
                    end else if (w_req_any || w_tmr_zero) begin
                        // On timeout viol_req is zero, so cause is unchanged
                        r_cause    <= r_cause | viol_req;
                        r_viol_cnt <= w_cnt_inc;
                        r_state    <= w_seq_state;
                        r_puc_rst  <= 1'b1;
                    end
                end
`ifdef RST_SEQ_LOCKOUT_EN
                ST_LOCKED: begin
                    r_puc_rst <= 1'b1;
                end
`endif
                default: begin
                    r_state   <= ST_IDLE;
                    r_puc_rst <= 1'b0;
                end
            endcase
        end
    end

    assign puc_rst  = r_puc_rst;
    assign viol_ack = r_viol_ack;
    assign cause    = r_cause;
    assign viol_cnt = r_viol_cnt;
    assign busy     = (r_state != ST_IDLE);

endmodule : puc_reset_sequencer
`default_nettype wire

// File: doc/puc_reset_sequencer.md
Name: puc_reset_sequencer

Overview:
- Receiving end of the monitor violation-reset interface: collects level reset requests from the hardware security monitors and issues the CPU power-up-clear (PUC).
- Holds PUC for a fixed window, then confirms the core restarts at the reset vector.
- Records which monitor fired and how often; sits between the monitors and the core's PUC input.

Parameters:
- NUM_SRC, 4, number of monitor request inputs
- HOLD_CYCLES, 16'd8, cycles PUC is held asserted per entry to HOLD (must be >= 1)
- WAIT_MAX, 16'd32, cycles allowed after PUC release for pc to reach RESET_HANDLER (must be >= 1)
- RESET_HANDLER, 16'hFFFE, reset vector address the core must fetch after release
- LOCK_THRESH, 8'd4, violation count that triggers lockout (used only with RST_SEQ_LOCKOUT_EN)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- viol_req  in  NUM_SRC  level reset requests from monitors, bit i = monitor i
- pc  in  16  current core program counter
- cause_clr  in  1  one-cycle pulse; clears cause when state is IDLE
- puc_rst  out  1  registered PUC to core, active-high
- viol_ack  out  1  one-cycle pulse: sequence completed, core back at vector
- cause  out  NUM_SRC  sticky OR of every request bit seen since the last clear
- viol_cnt  out  8  saturating count of reset sequences started
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset_n=0, async): state=IDLE, puc_rst=0, viol_ack=0, cause=0, viol_cnt=0, counter=0.
- All outputs are registered. viol_ack defaults to 0 every cycle unless set below.
- States: IDLE, HOLD, WAIT_VEC, plus LOCKED (macro only).
- IDLE:
  - On viol_req!=0, the next edge gives: state=HOLD, puc_rst=1, cause|=viol_req, viol_cnt+=1 (saturates at 255), counter=HOLD_CYCLES-1.
  - PUC therefore rises exactly one cycle after the request is sampled.
  - cause_clr is honoured only in IDLE and only when viol_req==0. If viol_req!=0, the request wins and cause_clr is ignored.
- HOLD:
  - puc_rst=1. Any viol_req bits are ORed into cause; viol_cnt does not change.
  - counter decrements each cycle. When counter==0, the next edge gives: state=WAIT_VEC, puc_rst=0, counter=WAIT_MAX-1.
  - puc_rst is high for exactly HOLD_CYCLES cycles.
- WAIT_VEC, evaluated in priority order:
  1. pc==RESET_HANDLER && viol_req==0 -> IDLE, viol_ack=1 for one cycle.
  2. viol_req!=0 -> HOLD; puc_rst=1, viol_cnt+=1, cause|=viol_req, counter reload.
  3. counter==0 (timeout) -> HOLD; viol_cnt+=1, counter reload, cause unchanged.
  4. Otherwise counter decrements.
- Monitors clear their own requests when pc==RESET_HANDLER. If pc hits the vector while a request is still high, rule 2 applies: this is a new sequence.
- cause_clr in any non-IDLE state: ignored.
- reset_n asserted mid-sequence: immediate return to the reset values above; puc_rst drops asynchronously.
- viol_cnt saturates at 8'hFF; it never wraps.

Optional Feature:
- RST_SEQ_LOCKOUT_EN defined:
  - Any transition into HOLD that makes viol_cnt >= LOCK_THRESH goes to LOCKED instead.
  - LOCKED: puc_rst=1 permanently, busy=1; viol_req, pc and cause_clr are ignored.
  - Exit only via reset_n.
- Not defined: no LOCKED state, LOCK_THRESH is unused, and sequences repeat indefinitely.

Decomposition:
- Shared package:
  - state enum (IDLE, HOLD, WAIT_VEC, LOCKED)
  - RESET_HANDLER constant, shared with the access monitors
  - 8-bit count width
- One natural sub-module: rst_seq_timer, a 16-bit loadable down-counter with load value, enable and zero flag. It is reused for both the HOLD and WAIT_VEC windows.

Test Plan:
- Single request: viol_req=4'b0001 for 1 cycle, pc reaches 16'hFFFE 5 cycles after release -> puc_rst high exactly 8 cycles starting 1 cycle after request; viol_ack one pulse; cause=4'b0001; viol_cnt=1; busy low after ack.
- Request during HOLD: bit0 then bit2 asserted at HOLD cycle 3 -> cause=4'b0101, viol_cnt stays 1, puc_rst width still 8.
- Timeout: pc never equals 16'hFFFE -> after 32 WAIT_VEC cycles, re-enter HOLD, viol_cnt=2, puc_rst pulses again for 8 cycles.
- Vector with request still high: pc=16'hFFFE while viol_req=4'b0010 in WAIT_VEC -> HOLD, no viol_ack, viol_cnt increments.
- cause_clr and saturation: cause_clr during busy -> cause unchanged; in IDLE -> cause=0. 260 sequences -> viol_cnt=255.
- Async reset mid-HOLD: reset_n low for 1 ns -> puc_rst=0 immediately, state IDLE, cause=0. With RST_SEQ_LOCKOUT_EN: 4th sequence -> LOCKED, puc_rst stays 1 until reset_n.
